// File: rtl/mio_bus_responder_if.sv
// mio_bus_responder_if: CPU data-bus request/response bundle
interface mio_bus_responder_if;
    logic        cpu_req;
    logic        cpu_mem_w;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mio_ready;
    modport master(output cpu_req, cpu_mem_w, cpu_addr, cpu_wdata, input cpu_rdata, mio_ready);
    modport slave(input cpu_req, cpu_mem_w, cpu_addr, cpu_wdata, output cpu_rdata, mio_ready);
endinterface

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: wait-stated RAM/IO responder with LED, switch and timer registers
module mio_bus_responder #(
    parameter int RAM_AW      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    mio_bus_responder_if.slave  bus,
    input  logic [15:0]         sw_in,
    output logic [15:0]         led_out,
    output logic                int_out
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state, state_n;
    logic [3:0]  cnt;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        mem_w;
    logic [31:0] ram [2**RAM_AW];
    logic [31:0] tcnt, tcmp, rd;
    logic        ten, tpend;
    logic        acc, wr, io, s_led, s_sw, s_cnt, s_cmp, s_ctl;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;
    always_comb begin
        state_n = (state == IDLE) ? (bus.cpu_req ? WAIT : IDLE)
                : (state == WAIT) ? (cnt == '0 ? RESP : WAIT)
                : IDLE;
        acc = (state == WAIT) && (cnt == '0);
        wr = acc && mem_w;
        bus.mio_ready = (state == RESP);
    end
    // addr holds the word address, so the IO page is bits [29:26] == 4'hF
    always_comb begin
        io    = addr[29:26] == 4'hF;
        s_led = addr == 30'h3C00_0000;
        s_sw  = addr == 30'h3C00_0001;
        s_cnt = addr == 30'h3C00_0002;
        s_cmp = addr == 30'h3C00_0003;
        s_ctl = addr == 30'h3C00_0004;
        rd = !io  ? ram[addr[RAM_AW-1:0]]
           : s_led ? {16'b0, led_out}
           : s_sw  ? {16'b0, sw_in}
           : s_cnt ? tcnt
           : s_cmp ? tcmp
           : s_ctl ? {30'b0, tpend, ten}
           : '0;
        int_out = tpend;
    end
    always_ff @(posedge clk)
        if (wr && !io) ram[addr[RAM_AW-1:0]] <= wdata;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt           <= '0;
            addr          <= '0;
            wdata         <= '0;
            mem_w         <= 1'b0;
            bus.cpu_rdata <= '0;
            led_out       <= '0;
            tcnt          <= '0;
            tcmp          <= '0;
            ten           <= 1'b0;
            tpend         <= 1'b0;
        end else begin
            if (state == IDLE && bus.cpu_req) begin
                cnt   <= 4'(WAIT_CYCLES);
                addr  <= bus.cpu_addr[31:2];
                wdata <= bus.cpu_wdata;
                mem_w <= bus.cpu_mem_w;
            end else if (state == WAIT && cnt != '0) cnt <= cnt - 4'd1;
            if (acc) bus.cpu_rdata <= mem_w ? '0 : rd;
            if (wr && s_led) led_out <= wdata[15:0];
            if (wr && s_cmp) tcmp <= wdata;
            if (wr && s_ctl) ten <= wdata[0];
            tcnt <= (wr && s_cnt) ? wdata : ten ? tcnt + 32'd1 : tcnt;
            // a match on the same edge as a clear keeps the interrupt pending
            tpend <= (ten && tcnt == tcmp) || (tpend && !(wr && s_ctl && wdata[1]));
        end
endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: randomized self-checking bench with a behavioural memory/register model
module tb_mio_bus_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sw_in = '0;
    logic [15:0] led0, led1;
    logic        int0, int1;
    int          vectors = 0, miscompares = 0;
    logic [31:0] mram [int];
    int          widx [$];
    logic [15:0] mled = '0;
    mio_bus_responder_if b0();
    mio_bus_responder_if b1();
    mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .bus(b0.slave), .sw_in(sw_in), .led_out(led0), .int_out(int0));
    mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(b1.slave), .sw_in(sw_in), .led_out(led1), .int_out(int1));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end
    // one transaction on the WAIT_CYCLES=1 responder; lat = edges after the request edge until mio_ready
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdata, output int lat, output logic stuck);
        b0.cpu_req = 1'b1; b0.cpu_mem_w = w; b0.cpu_addr = a; b0.cpu_wdata = d;
        @(posedge clk); #1;
        b0.cpu_req = 1'b0; b0.cpu_addr = $urandom; b0.cpu_wdata = $urandom; b0.cpu_mem_w = $urandom;
        lat = 99; rdata = '0;
        if (b0.mio_ready) begin lat = 0; rdata = b0.cpu_rdata; end
        else for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (b0.mio_ready) begin lat = i; rdata = b0.cpu_rdata; break; end
        end
        @(posedge clk); #1;
        stuck = b0.mio_ready;
    endtask
    task automatic test_reset();
        vectors++; if (b0.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h required 0", b0.cpu_rdata); end
        vectors++; if (b0.mio_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b required 0", b0.mio_ready); end
        vectors++; if (led0 !== 16'h0) begin miscompares++; $display("FAIL reset_led: got %h required 0", led0); end
        vectors++; if (int0 !== 1'b0) begin miscompares++; $display("FAIL reset_int: got %b required 0", int0); end
    endtask
    task automatic test_ram_basic();
        logic [31:0] rd; int lat; logic st;
        txn(1'b1, 32'h0000_0010, 32'h1234_5678, rd, lat, st);
        mram[4] = 32'h1234_5678; widx.push_back(4);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wr_latency: got %0d required 2", lat); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL wr_rdata: got %h required 0", rd); end
        vectors++; if (st !== 1'b0) begin miscompares++; $display("FAIL ready_pulse_width: got %b required 0", st); end
        txn(1'b0, 32'h0000_0010, 32'h0, rd, lat, st);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rd_latency: got %0d required 2", lat); end
        vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL ram_read: got %h required 12345678", rd); end
    endtask
    task automatic test_io();
        logic [31:0] rd; int lat; logic st;
        txn(1'b1, 32'hF000_0000, 32'h0000_00A5, rd, lat, st);
        mled = 16'h00A5;
        vectors++; if (led0 !== 16'h00A5) begin miscompares++; $display("FAIL led_write: got %h required 00a5", led0); end
        sw_in = 16'hBEEF;
        txn(1'b0, 32'hF000_0004, 32'h0, rd, lat, st);
        vectors++; if (rd !== 32'h0000_BEEF) begin miscompares++; $display("FAIL sw_read: got %h required 0000beef", rd); end
    endtask
    task automatic test_random();
        logic [31:0] rd, a, d, exp; int lat, idx; logic st;
        for (int n = 0; n < 60; n++) begin
            d = $urandom;
            case ($urandom_range(0, 4))
                0: begin
                    a = $urandom % 32'hF000_0000;
                    idx = int'((a >> 2) % 1024);
                    txn(1'b1, a, d, rd, lat, st);
                    mram[idx] = d; widx.push_back(idx);
                    exp = 32'h0;
                end
                1: begin
                    idx = widx[$urandom_range(0, widx.size() - 1)];
                    a = 32'(idx) * 4 + 32'(4096 * $urandom_range(0, 32'hEFFFF)) + 32'($urandom_range(0, 3));
                    txn(1'b0, a, 32'h0, rd, lat, st);
                    exp = mram[idx];
                end
                2: begin
                    txn(1'b1, 32'hF000_0000, d, rd, lat, st);
                    mled = d[15:0];
                    exp = 32'h0;
                    vectors++; if (led0 !== mled) begin miscompares++; $display("FAIL rand_led: got %h required %h", led0, mled); end
                end
                3: begin
                    sw_in = 16'($urandom);
                    txn(1'b0, 32'hF000_0004, d, rd, lat, st);
                    exp = {16'b0, sw_in};
                end
                default: begin
                    txn(1'b0, 32'hF000_0000, d, rd, lat, st);
                    exp = {16'b0, mled};
                end
            endcase
            vectors++; if (rd !== exp) begin miscompares++; $display("FAIL rand_data[%0d]: got %h required %h", n, rd, exp); end
            vectors++; if (lat !== 2 || st !== 1'b0) begin miscompares++; $display("FAIL rand_timing[%0d]: got lat %0d stuck %b required lat 2 stuck 0", n, lat, st); end
        end
    endtask
    task automatic test_unmapped();
        logic [31:0] rd; int lat; logic st;
        sw_in = 16'h1234;
        txn(1'b0, 32'hF000_0004, 32'h0, rd, lat, st);
        txn(1'b0, 32'hF000_0020, 32'h0, rd, lat, st);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL unmapped_read: got %h required 0", rd); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL unmapped_ready: got %0d required 2", lat); end
        txn(1'b1, 32'hF000_0004, 32'h1, rd, lat, st);
        vectors++; if (led0 !== mled) begin miscompares++; $display("FAIL sw_write_led: got %h required %h", led0, mled); end
        txn(1'b0, 32'hF000_0004, 32'h0, rd, lat, st);
        vectors++; if (rd !== 32'h0000_1234) begin miscompares++; $display("FAIL sw_write_ignored: got %h required 00001234", rd); end
    endtask
    task automatic test_timer();
        logic [31:0] rd; int lat; logic st;
        txn(1'b1, 32'hF000_000C, 32'd5, rd, lat, st);
        txn(1'b1, 32'hF000_0008, 32'd0, rd, lat, st);
        txn(1'b1, 32'hF000_0010, 32'd1, rd, lat, st);
        // count is 1 now; it reaches 5 four edges later, and the match edge follows
        repeat (4) @(posedge clk); #1;
        vectors++; if (int0 !== 1'b0) begin miscompares++; $display("FAIL timer_early: got %b required 0", int0); end
        @(posedge clk); #1;
        vectors++; if (int0 !== 1'b1) begin miscompares++; $display("FAIL timer_match: got %b required 1", int0); end
        txn(1'b1, 32'hF000_0010, 32'd3, rd, lat, st);
        vectors++; if (int0 !== 1'b0) begin miscompares++; $display("FAIL timer_clear: got %b required 0", int0); end
        txn(1'b1, 32'hF000_0008, 32'd2, rd, lat, st);
        txn(1'b1, 32'hF000_0010, 32'd3, rd, lat, st);
        vectors++; if (int0 !== 1'b1) begin miscompares++; $display("FAIL timer_set_wins: got %b required 1", int0); end
        txn(1'b0, 32'hF000_0010, 32'd0, rd, lat, st);
        vectors++; if (rd !== 32'h3) begin miscompares++; $display("FAIL tctl_read: got %h required 3", rd); end
        txn(1'b0, 32'hF000_000C, 32'd0, rd, lat, st);
        vectors++; if (rd !== 32'd5) begin miscompares++; $display("FAIL tcmp_read: got %h required 5", rd); end
    endtask
    task automatic test_back_to_back();
        logic [31:0] d;
        d = $urandom;
        b1.cpu_req = 1'b1; b1.cpu_mem_w = 1'b1; b1.cpu_addr = 32'hF000_0000; b1.cpu_wdata = d;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            vectors++; if (b1.mio_ready !== (i % 3 == 1)) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b required %b", i, b1.mio_ready, i % 3 == 1); end
        end
        b1.cpu_req = 1'b0;
        repeat (3) @(posedge clk); #1;
        vectors++; if (led1 !== d[15:0]) begin miscompares++; $display("FAIL b2b_led: got %h required %h", led1, d[15:0]); end
    endtask
    task automatic test_reset_mid();
        logic [31:0] rd; int lat; logic st;
        txn(1'b1, 32'h0000_0020, 32'hCAFE_F00D, rd, lat, st);
        mram[8] = 32'hCAFE_F00D;
        b0.cpu_req = 1'b1; b0.cpu_mem_w = 1'b1; b0.cpu_addr = 32'h0000_0020; b0.cpu_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        b0.cpu_req = 1'b0;
        reset = 1'b1;
        mled = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++; if (b0.mio_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mid_ready[%0d]: got %b required 0", i, b0.mio_ready); end
        end
        reset = 1'b0;
        vectors++; if (led0 !== 16'h0) begin miscompares++; $display("FAIL reset_mid_led: got %h required 0", led0); end
        vectors++; if (int0 !== 1'b0) begin miscompares++; $display("FAIL reset_mid_int: got %b required 0", int0); end
        txn(1'b0, 32'h0000_0020, 32'h0, rd, lat, st);
        vectors++; if (rd !== mram[8]) begin miscompares++; $display("FAIL reset_mid_lost_write: got %h required %h", rd, mram[8]); end
    endtask
    initial begin
        b0.cpu_req = 1'b0; b0.cpu_mem_w = 1'b0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
        b1.cpu_req = 1'b0; b1.cpu_mem_w = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
        repeat (3) @(posedge clk); #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_ram_basic();
        test_io();
        test_random();
        test_unmapped();
        test_timer();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
